// File: rtl/i2c_target_pkg.sv
// Shared FSM state type and bus constants for the I2C target register block.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad-side I2C lines plus the local register host port of the target block.
interface i2c_target_regs_if #(
    parameter int PTR_W = 4
);

    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             busy;
    logic             wr_strobe;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_rdata;

    modport slave (
        input  scl_i,
        input  sda_i,
        input  host_addr,
        output sda_oe,
        output busy,
        output wr_strobe,
        output wr_addr,
        output wr_data,
        output host_rdata
    );

    modport master (
        output scl_i,
        output sda_i,
        output host_addr,
        input  sda_oe,
        input  busy,
        input  wr_strobe,
        input  wr_addr,
        input  wr_data,
        input  host_rdata
    );

endinterface

// File: rtl/i2c_line_cond.sv
// Synchronizer, optional glitch filter and edge detect for one I2C line.
// Filter stage present only when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_line_cond #(
    parameter logic RST_LVL = 1'b1
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_LVL;
            sync_q <= RST_LVL;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [FILT_LEN-1:0] filt_q;
    logic                filt_lvl_q;

    // Level only moves once every sample in the window agrees.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= {FILT_LEN{RST_LVL}};
            filt_lvl_q <= RST_LVL;
        end else begin
            filt_q <= FILT_LEN'({filt_q, sync_q});
            if (&filt_q) begin
                filt_lvl_q <= 1'b1;
            end else if (~|filt_q) begin
                filt_lvl_q <= 1'b0;
            end
        end
    end

    assign level = filt_lvl_q;
`else
    assign level = sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RST_LVL;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with pointer-addressed byte register file and host read port.
// Define I2C_TARGET_GLITCH_FILTER_EN to add the FILT_LEN-deep line filters.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         PTR_W       = 4
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    ,
    parameter int         FILT_LEN    = 3
`endif
) (
    input logic              clk,
    input logic              rst,
    i2c_target_regs_if.slave bus
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] FULL     = 4'(BITS_PER_BYTE);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [6:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       rx_byte;
    logic             we;
    logic [7:0]       regs_q [DEPTH];

    i2c_line_cond #(
        .RST_LVL (1'b1)
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        ,
        .FILT_LEN(FILT_LEN)
`endif
    ) u_scl (
        .clk    (clk),
        .rst    (rst),
        .line_i (bus.scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_cond #(
        .RST_LVL (1'b1)
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        ,
        .FILT_LEN(FILT_LEN)
`endif
    ) u_sda (
        .clk    (clk),
        .rst    (rst),
        .line_i (bus.sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start   = sda_fall & scl_lvl;
    assign stop    = sda_rise & scl_lvl;
    assign rx_byte = {shift_q, sda_lvl};
    assign ptr_inc = ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        we          = 1'b0;

        if (scl_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 4'd1;
        end

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, IGNORE: ;
                ADDR: begin
                    if (scl_rise && cnt_q == LAST_BIT) begin
                        rw_d    = rx_byte[0];
                        cnt_d   = '0;
                        state_d = (rx_byte[7:1] == TARGET_ADDR)
                                ? ADDR_ACK : IGNORE;
                    end
                end
                // First fall starts the ACK, second fall ends it.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (!oe_q) begin
                            oe_d = ~I2C_ACK;
                        end else if (rw_q) begin
                            tx_d    = regs_q[ptr_q][6:0];
                            oe_d    = ~regs_q[ptr_q][7];
                            state_d = RDATA;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise && cnt_q == LAST_BIT) begin
                        ptr_d   = rx_byte[PTR_W-1:0];
                        cnt_d   = '0;
                        state_d = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (!oe_q) begin
                            oe_d = ~I2C_ACK;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise && cnt_q == LAST_BIT) begin
                        we          = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        wr_data_d   = rx_byte;
                        ptr_d       = ptr_inc;
                        cnt_d       = '0;
                        state_d     = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == FULL) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = RACK;
                        end else begin
                            oe_d = ~tx_q[6];
                            tx_d = {tx_q[5:0], 1'b0};
                        end
                    end
                end
                RACK: begin
                    if (scl_rise && sda_lvl == I2C_NACK) begin
                        state_d = IGNORE;
                    end else if (scl_fall) begin
                        ptr_d   = ptr_inc;
                        tx_d    = regs_q[ptr_inc][6:0];
                        oe_d    = ~regs_q[ptr_inc][7];
                        cnt_d   = '0;
                        state_d = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[ptr_q] <= rx_byte;
        end
    end

    assign bus.sda_oe     = oe_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.wr_strobe  = wr_strobe_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.host_rdata = regs_q[bus.host_addr];

endmodule
